collision_monitor: RTL and testbench
====================================

// Module: collision_monitor
// PURPOSE
//   Frame-rate game supervisor. It consumes the dino bounding box (X/Y/width/height)
//   published by the dino delegate and the boxes of up to two obstacles. It detects
//   box overlap, runs the IDLE/RUN/DEAD game FSM and drives isDead back to the dino FSM.
//   It sits between the dino delegate, the obstacle generators and the score display.
// PARAMETERS
//   MARGIN      default 4    pixels trimmed from each side of the dino box (forgiving hitbox)
//   HIT_FRAMES  default 2    consecutive overlapping frames required to declare death (>=1)
//   DEAD_HOLD   default 30   frames in DEAD before a restart press is accepted (>=1)
// PORTS
//   FrameClk    in   1   frame clock, one rising edge per video frame
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   jump button, level; only rising edges are used
//   Dino_X      in   11  dino box left edge
//   Dino_Y      in   11  dino box top edge
//   DinoWidth   in   10  dino box width
//   DinoHeight  in   10  dino box height
//   obs0_x/obs0_y  in  11  obstacle 0 left/top edge
//   obs0_w/obs0_h  in  10  obstacle 0 width/height
//   obs0_valid  in   1   obstacle 0 on screen
//   obs1_*      in   -   same set for obstacle 1
//   running     out  1   FSM in RUN
//   isDead      out  1   FSM in DEAD
//   collide     out  1   overlap was detected at the last edge (registered)
//   hit_cnt     out  4   consecutive-overlap counter
//   score       out  16  frames survived in the current run
// BEHAVIOUR
//   - Reset (async): state=IDLE; running, isDead, collide, hit_cnt, score, start_q, hold_cnt all 0.
//   - start_q <= start on every edge. press = start & ~start_q.
//   - Overlap, combinational:
//       dino box = [X+MARGIN, X+W-MARGIN) x [Y+MARGIN, Y+H-MARGIN).
//       Dino box is empty (never overlaps) if W<=2*MARGIN or H<=2*MARGIN.
//       Per obstacle: valid & ax0<bx1 & bx0<ax1 & ay0<by1 & by0<ay1.
//       All sums use 12-bit unsigned, so no wrap. Zero-width/height obstacle never overlaps.
//       Edges that only touch do not overlap.
//       ovl = ovl0 | ovl1.
//   - collide <= ovl on every edge, in any state.
//   - IDLE:
//       press -> RUN; score<=0; hit_cnt<=0.
//   - RUN:
//       score <= score+1 per edge, saturating at 16'hFFFF.
//       hit_cnt <= ovl ? hit_cnt+1 : 0, saturating at 15.
//       If ovl and hit_cnt+1 >= HIT_FRAMES -> DEAD; hold_cnt<=0.
//       isDead is 1 from that same edge, i.e. after HIT_FRAMES consecutive overlapping edges.
//       On the death edge score is not incremented.
//   - DEAD:
//       score and hit_cnt frozen.
//       hold_cnt counts up, saturating at DEAD_HOLD.
//       press while hold_cnt==DEAD_HOLD -> RUN; score<=0; hit_cnt<=0.
//       Earlier presses are ignored. A held button needs release and re-press.
//   - Press and overlap on the same RUN edge: overlap rule applies, press is ignored.
//   - running/isDead are registered decodes of state and are mutually exclusive.
//   - Reset asserted mid-run or in DEAD returns to IDLE immediately. No press is pending after release.
// CONFIGURATION
//   COLLISION_INVULN_EN
//     Defined: overlap still drives collide and hit_cnt, but RUN never enters DEAD.
//       isDead stays 0 and score keeps counting (debug/attract mode).
//     Undefined: normal death behaviour as above.
// TESTING
//   1 Reset, start pulse 0->1 -> running=1 next edge; score=1,2,3 on following edges.
//   2 Dino 50,300,40x43; obs0 at x=70,y=310,17x35, valid; HIT_FRAMES=2 ->
//       collide=1 at edge 1, isDead=1 at edge 2, score frozen.
//   3 Obstacle touching the trimmed box (obs0_x = 50+40-4 = 86) -> collide stays 0 and run continues.
//     obs0_x=85 -> collide=1.
//   4 Single-frame overlap then clear -> hit_cnt 1 then 0; no death.
//   5 DEAD: press at hold_cnt=10 is ignored; press after 30 frames -> RUN with score=0.
//     Button held through the DEAD->RUN boundary produces no second restart.
//   6 Reset asserted mid-RUN with score=100 -> all outputs 0 asynchronously, state IDLE.
//     With COLLISION_INVULN_EN, test 2 gives isDead=0, collide=1, score counting.

Source files
------------

// File: rtl/collision_monitor.sv
// collision_monitor: box-overlap detector and IDLE/RUN/DEAD game supervisor (optional COLLISION_INVULN_EN disables death)
module collision_monitor #(
    parameter int MARGIN     = 4,
    parameter int HIT_FRAMES = 2,
    parameter int DEAD_HOLD  = 30
) (
    input  logic        FrameClk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] Dino_X,
    input  logic [10:0] Dino_Y,
    input  logic [9:0]  DinoWidth,
    input  logic [9:0]  DinoHeight,
    input  logic [10:0] obs0_x,
    input  logic [10:0] obs0_y,
    input  logic [9:0]  obs0_w,
    input  logic [9:0]  obs0_h,
    input  logic        obs0_valid,
    input  logic [10:0] obs1_x,
    input  logic [10:0] obs1_y,
    input  logic [9:0]  obs1_w,
    input  logic [9:0]  obs1_h,
    input  logic        obs1_valid,
    output logic        running,
    output logic        isDead,
    output logic        collide,
    output logic [3:0]  hit_cnt,
    output logic [15:0] score
);
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    localparam int HW = $clog2(DEAD_HOLD + 1);
    localparam logic [11:0] M = 12'(MARGIN);
    localparam logic [11:0] M2 = 12'(2 * MARGIN);
    localparam logic [4:0] HF = 5'(HIT_FRAMES);
    localparam logic [HW-1:0] DH = HW'(DEAD_HOLD);
    state_t state, nextState;
    logic startQ, press, dinoOk, ovl, die, holdFull;
    logic [11:0] ax0, ax1, ay0, ay1;
    logic [HW-1:0] holdCnt, holdNext;
    logic [15:0] scoreNext;
    logic [3:0] hitNext, hitInc;
    function automatic logic boxHit(input logic [10:0] x, input logic [10:0] y,
                                    input logic [9:0] w, input logic [9:0] h, input logic v);
        return v && w != 0 && h != 0 &&
               ax0 < {1'b0, x} + {2'b0, w} && {1'b0, x} < ax1 &&
               ay0 < {1'b0, y} + {2'b0, h} && {1'b0, y} < ay1;
    endfunction
    assign press = start & ~startQ;
    assign ax0 = {1'b0, Dino_X} + M;
    assign ax1 = {1'b0, Dino_X} + {2'b0, DinoWidth} - M;
    assign ay0 = {1'b0, Dino_Y} + M;
    assign ay1 = {1'b0, Dino_Y} + {2'b0, DinoHeight} - M;
    assign dinoOk = ({2'b0, DinoWidth} > M2) && ({2'b0, DinoHeight} > M2);
    assign ovl = dinoOk && (boxHit(obs0_x, obs0_y, obs0_w, obs0_h, obs0_valid) ||
                            boxHit(obs1_x, obs1_y, obs1_w, obs1_h, obs1_valid));
    assign hitInc = &hit_cnt ? hit_cnt : hit_cnt + 4'd1;
    assign holdFull = holdCnt == DH;
`ifdef COLLISION_INVULN_EN
    assign die = 1'b0;
`else
    assign die = ovl && ({1'b0, hit_cnt} + 5'd1 >= HF);
`endif
    // next-state, score, hit and hold counter updates
    always_comb begin
        nextState = state;
        scoreNext = score;
        hitNext = hit_cnt;
        holdNext = holdCnt;
        case (state)
            IDLE: if (press) begin
                nextState = RUN;
                scoreNext = '0;
                hitNext = '0;
            end
            RUN: begin
                hitNext = ovl ? hitInc : 4'd0;
                if (die) begin
                    nextState = DEAD;
                    holdNext = '0;
                end else scoreNext = &score ? score : score + 16'd1;
            end
            DEAD: if (press && holdFull) begin
                nextState = RUN;
                scoreNext = '0;
                hitNext = '0;
            end else holdNext = holdFull ? holdCnt : holdCnt + 1'b1;
            default: nextState = IDLE;
        endcase
    end
    // state and registered outputs, async reset
    always_ff @(posedge FrameClk or posedge rst)
        if (rst) begin
            state <= IDLE;
            running <= 1'b0;
            isDead <= 1'b0;
            collide <= 1'b0;
            hit_cnt <= '0;
            score <= '0;
            startQ <= 1'b0;
            holdCnt <= '0;
        end else begin
            state <= nextState;
            running <= nextState == RUN;
            isDead <= nextState == DEAD;
            collide <= ovl;
            hit_cnt <= hitNext;
            score <= scoreNext;
            startQ <= start;
            holdCnt <= holdNext;
        end
endmodule

// File: tb/tb_collision_monitor.sv
// tb_collision_monitor: directed table-driven bench for collision_monitor
module tb_collision_monitor;
    logic FrameClk = 0, rst = 1, start = 0;
    logic [10:0] Dino_X = 50, Dino_Y = 300, obs0_x = 500, obs0_y = 310, obs1_x = 70, obs1_y = 310;
    logic [9:0] DinoWidth = 40, DinoHeight = 43, obs0_w = 17, obs0_h = 35, obs1_w = 17, obs1_h = 35;
    logic obs0_valid = 1, obs1_valid = 0;
    logic running, isDead, collide;
    logic [3:0] hit_cnt;
    logic [15:0] score;
    int checks = 0, errors = 0;
    int expScore;

    typedef struct {
        logic st;
        logic [10:0] ox;
        logic [9:0] ow;
        logic ov;
        logic o1v;
        logic [9:0] dw;
        logic [22:0] ex;
    } vec_t;
    vec_t tbl[15];

    collision_monitor dut (
        .FrameClk(FrameClk), .rst(rst), .start(start),
        .Dino_X(Dino_X), .Dino_Y(Dino_Y), .DinoWidth(DinoWidth), .DinoHeight(DinoHeight),
        .obs0_x(obs0_x), .obs0_y(obs0_y), .obs0_w(obs0_w), .obs0_h(obs0_h), .obs0_valid(obs0_valid),
        .obs1_x(obs1_x), .obs1_y(obs1_y), .obs1_w(obs1_w), .obs1_h(obs1_h), .obs1_valid(obs1_valid),
        .running(running), .isDead(isDead), .collide(collide), .hit_cnt(hit_cnt), .score(score)
    );

    always #5 FrameClk = ~FrameClk;

    function automatic logic [22:0] e(input logic r, input logic d, input logic c,
                                      input logic [3:0] h, input logic [15:0] s);
        return {r, d, c, h, s};
    endfunction

    function automatic vec_t mk(input logic st, input logic [10:0] ox, input logic [9:0] ow,
                                input logic ov, input logic o1v, input logic [9:0] dw,
                                input logic [22:0] ex);
        vec_t v;
        v.st = st; v.ox = ox; v.ow = ow; v.ov = ov; v.o1v = o1v; v.dw = dw; v.ex = ex;
        return v;
    endfunction

    task automatic check(input string name, input logic [22:0] exp);
        logic [22:0] act;
        act = {running, isDead, collide, hit_cnt, score};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got run=%b dead=%b col=%b hit=%0d score=%0d, expected run=%b dead=%b col=%b hit=%0d score=%0d",
                     name, act[22], act[21], act[20], act[19:16], act[15:0],
                     exp[22], exp[21], exp[20], exp[19:16], exp[15:0]);
        end
    endtask

    task automatic step(input logic s);
        @(negedge FrameClk);
        start = s;
        @(posedge FrameClk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 500, 17, 1, 0, 40, e(0, 0, 0, 0, 0));
        tbl[1]  = mk(1, 500, 17, 1, 0, 40, e(1, 0, 0, 0, 0));
        tbl[2]  = mk(1, 500, 17, 1, 0, 40, e(1, 0, 0, 0, 1));
        tbl[3]  = mk(0, 500, 17, 1, 0, 40, e(1, 0, 0, 0, 2));
        tbl[4]  = mk(0, 500, 17, 1, 0, 40, e(1, 0, 0, 0, 3));
        tbl[5]  = mk(0, 86, 17, 1, 0, 40, e(1, 0, 0, 0, 4));
        tbl[6]  = mk(0, 85, 17, 1, 0, 40, e(1, 0, 1, 1, 5));
        tbl[7]  = mk(0, 500, 17, 1, 0, 40, e(1, 0, 0, 0, 6));
        tbl[8]  = mk(0, 85, 17, 0, 0, 40, e(1, 0, 0, 0, 7));
        tbl[9]  = mk(0, 500, 17, 1, 1, 40, e(1, 0, 1, 1, 8));
        tbl[10] = mk(0, 70, 17, 1, 0, 8, e(1, 0, 0, 0, 9));
        tbl[11] = mk(0, 70, 0, 1, 0, 40, e(1, 0, 0, 0, 10));
        tbl[12] = mk(1, 70, 17, 1, 0, 40, e(1, 0, 1, 1, 11));
`ifdef COLLISION_INVULN_EN
        tbl[13] = mk(0, 70, 17, 1, 0, 40, e(1, 0, 1, 2, 12));
        tbl[14] = mk(0, 70, 17, 1, 0, 40, e(1, 0, 1, 3, 13));
        expScore = 13;
`else
        tbl[13] = mk(0, 70, 17, 1, 0, 40, e(0, 1, 1, 2, 11));
        tbl[14] = mk(0, 70, 17, 1, 0, 40, e(0, 1, 1, 2, 11));
        expScore = 11;
`endif
        #12;
        check("reset_state", e(0, 0, 0, 0, 0));
        @(negedge FrameClk);
        rst = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge FrameClk);
            start = tbl[i].st;
            obs0_x = tbl[i].ox;
            obs0_w = tbl[i].ow;
            obs0_valid = tbl[i].ov;
            obs1_valid = tbl[i].o1v;
            DinoWidth = tbl[i].dw;
            @(posedge FrameClk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].ex);
        end
        @(negedge FrameClk);
        obs0_x = 500;
`ifndef COLLISION_INVULN_EN
        for (int i = 0; i < 9; i++) step(0);
        step(1);
        check("press_at_hold10", e(0, 1, 0, 2, 11));
        for (int i = 0; i < 19; i++) step(0);
        check("hold_saturated", e(0, 1, 0, 2, 11));
        step(1);
        check("restart", e(1, 0, 0, 0, 0));
        step(1);
        check("held_no_restart1", e(1, 0, 0, 0, 1));
        step(1);
        check("held_no_restart2", e(1, 0, 0, 0, 2));
        expScore = 2;
`endif
        while (expScore < 100) begin
            step(0);
            expScore++;
        end
        check("score_100", e(1, 0, 0, 0, 100));
        #2 rst = 1;
        #1 check("async_reset", e(0, 0, 0, 0, 0));
        @(negedge FrameClk);
        rst = 0;
        step(0);
        check("idle_after_reset", e(0, 0, 0, 0, 0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
